// File: rtl/fifo_ctrl.sv
// Sequencing controller for an 8-entry FIFO.
// Keeps head/tail/count and drives register-file strobes.
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [2:0]    state,
  output logic [CW-1:0] data_count,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic          we_rf,
  output logic          re_rf
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t state_q;
  state_t state_d;
  logic   full;
  logic   empty;
  logic   wr_only;
  logic   rd_only;
  logic   illegal;

  assign full    = (data_count == FULL_CNT);
  assign empty   = (data_count == '0);
  assign wr_only = wr_en & ~rd_en;
  assign rd_only = rd_en & ~wr_en;
  assign illegal = state_q[2] & state_q[1];

  assign we_rf = reset_n & wr_only & ~full;
  assign re_rf = reset_n & rd_only & ~empty;
  assign state = state_q;

  always_comb begin
    state_d = NO_OP;
    if (illegal) begin
      state_d = INIT;
    end else begin
      unique case (1'b1)
        wr_only & ~full:  state_d = WRITE;
        wr_only & full:   state_d = WR_ERROR;
        rd_only & ~empty: state_d = READ;
        rd_only & empty:  state_d = RD_ERROR;
        default:          state_d = NO_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      state_q <= state_d;
      // An unused state code also scrubs the datapath.
      if (illegal) begin
        head       <= '0;
        tail       <= '0;
        data_count <= '0;
      end else if (state_d == WRITE) begin
        tail       <= tail + AW'(1);
        data_count <= data_count + CW'(1);
      end else if (state_d == READ) begin
        head       <= head + AW'(1);
        data_count <= data_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl.
// Inputs change on negedge; outputs sampled #1 after posedge.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] state;
  logic [3:0] data_count;
  logic [2:0] head;
  logic [2:0] tail;
  logic       we_rf;
  logic       re_rf;

  int errs;
  int checks;

  fifo_ctrl #(.DEPTH(8), .AW(3), .CW(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .state      (state),
    .data_count (data_count),
    .head       (head),
    .tail       (tail),
    .we_rf      (we_rf),
    .re_rf      (re_rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    reset_n = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    #3;
    check("rst_state", state, 0);
    check("rst_count", data_count, 0);
    check("rst_head", head, 0);
    check("rst_tail", tail, 0);
    check("rst_we", we_rf, 0);
    tick();
    check("rst_hold", state, 0);

    @(negedge clk);
    reset_n = 1'b1;
    wr_en   = 1'b0;
    tick();
    check("idle_state", state, 1);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      check("fill_we", we_rf, 1);
      tick();
      check("fill_state", state, 2);
      check("fill_count", data_count, i + 1);
      check("fill_tail", tail, (i + 1) % 8);
    end
    drive(1'b1, 1'b0);
    check("ovf_we", we_rf, 0);
    tick();
    check("ovf_state", state, 3);
    check("ovf_count", data_count, 8);
    check("ovf_tail", tail, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      check("drain_re", re_rf, 1);
      tick();
      check("drain_state", state, 4);
      check("drain_count", data_count, 7 - i);
      check("drain_head", head, (i + 1) % 8);
    end
    drive(1'b0, 1'b1);
    check("unf_re", re_rf, 0);
    tick();
    check("unf_state", state, 5);
    check("unf_count", data_count, 0);
    check("unf_head", head, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    check("pre_sim_count", data_count, 3);
    drive(1'b1, 1'b1);
    check("sim_we", we_rf, 0);
    check("sim_re", re_rf, 0);
    tick();
    check("sim_state", state, 1);
    check("sim_count", data_count, 3);
    check("sim_head", head, 0);
    check("sim_tail", tail, 3);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    check("il_head5", head, 5);
    check("il_tail5", tail, 5);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    check("il_tail", tail, 1);
    check("il_head", head, 7);
    check("il_count", data_count, 2);
    check("il_inv", 32'((tail - head) & 3'd7), 2);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    check("mid_count6", data_count, 6);
    drive(1'b1, 1'b0);
    check("mid_we_pre", we_rf, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_state", state, 0);
    check("mid_count", data_count, 0);
    check("mid_tail", tail, 0);
    check("mid_we", we_rf, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_we", we_rf, 1);
    tick();
    check("post_state", state, 2);
    check("post_count", data_count, 1);
    check("post_tail", tail, 1);

    drive(1'b0, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequencing controller for the 8-entry FIFO. Each cycle it samples the write and read requests and decides the FIFO operation. It keeps the head/tail pointers and the occupancy count, and drives the register-file write/read strobes and addresses. Its registered `state` and `data_count` outputs feed the FIFO status decoder (full/empty/ack/err flags) directly.

## Interface
- DEPTH, 8, number of FIFO entries; must be a power of two.
- AW, 3, pointer width, log2(DEPTH).
- CW, 4, count width, AW+1, so the count can hold 0..DEPTH.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; one clock, asynchronous and active-low.
- wr_en  in  1  write request from the producer.
- rd_en  in  1  read request from the consumer.
- state  out  3  registered FIFO operation code (encoding below).
- data_count  out  CW  registered occupancy, 0..DEPTH.
- head  out  AW  registered read pointer.
- tail  out  AW  registered write pointer.
- we_rf  out  1  combinational register-file write strobe; write address = tail.
- re_rf  out  1  combinational register-file read strobe; read address = head.

## Operation
- State encoding:
  - INIT = 000
  - NO_OP = 001
  - WRITE = 010
  - WR_ERROR = 011
  - READ = 100
  - RD_ERROR = 101
  - 110 and 111 are unused.
- Next-state decision, evaluated every cycle from the current wr_en, rd_en and data_count:
  - wr_en=1, rd_en=0, data_count<DEPTH → WRITE.
  - wr_en=1, rd_en=0, data_count==DEPTH → WR_ERROR.
  - rd_en=1, wr_en=0, data_count>0 → READ.
  - rd_en=1, wr_en=0, data_count==0 → RD_ERROR.
  - wr_en=0, rd_en=0 → NO_OP.
  - wr_en=1, rd_en=1 → NO_OP. Simultaneous requests are rejected; no pointer or count change.
- Strobes, combinational and qualified by the same conditions:
  - we_rf = reset_n & wr_en & ~rd_en & (data_count<DEPTH).
  - re_rf = reset_n & rd_en & ~wr_en & (data_count>0).
- Register updates at the same edge that loads WRITE or READ:
  - WRITE: tail ← tail+1 mod DEPTH; data_count ← data_count+1.
  - READ: head ← head+1 mod DEPTH; data_count ← data_count−1.
  - All other next states: head, tail and data_count hold.
- Pointer arithmetic is AW-bit with natural wrap (7+1 → 0).
- data_count never leaves 0..DEPTH: the error states block overflow and underflow.
- Invariant: (tail − head) mod DEPTH == data_count mod DEPTH.
- If state ever holds 110 or 111, the next state is INIT, and head, tail and data_count reset to 0.

## Timing
- Reset:
  - While reset_n=0, asynchronously: state=INIT, data_count=0, head=0, tail=0, we_rf=0, re_rf=0.
  - INIT persists until the first rising edge after reset_n deasserts.
  - The next state is then decoded normally; INIT is never re-entered except by reset or an illegal code.
- Latency:
  - A request sampled at edge N is reflected in state/data_count/pointers immediately after edge N.
  - Status flags from the decoder are therefore valid one cycle after the request is presented.
- Register-file write: we_rf and the address (tail) are valid before edge N, so the write completes at edge N; tail advances at the same edge.
- Register-file read: re_rf and the address (head) are valid before edge N, so the read data is captured at edge N; head advances at the same edge.
- Back-to-back requests on consecutive cycles are fully supported, one operation per cycle.
- Reset asserted mid-operation clears everything immediately. Any in-flight write whose edge has not occurred is lost; its strobe drops asynchronously with reset_n.
- Boundaries:
  - Write at data_count=7 → WRITE, count 8.
  - Next write → WR_ERROR, count stays 8, we_rf=0, tail holds.
  - Read at count=1 → READ, count 0.
  - Next read → RD_ERROR, re_rf=0, head holds.

## Test plan
- Reset and idle: assert reset_n=0 with wr_en=1 → state=000, count=0, head=tail=0, we_rf=0. Release with wr_en=rd_en=0 → state=001 after the first edge.
- Fill and wrap: eight consecutive wr_en cycles from empty:
  - data_count steps 1..8, tail steps 1..7 then 0, state=010 throughout.
  - A ninth write gives state=011, count=8, tail=0, we_rf=0.
- Drain and underflow: from full, eight rd_en cycles:
  - head wraps to 0, count reaches 0, state=100 throughout.
  - A ninth read gives state=101, re_rf=0, head=0.
- Simultaneous requests: at count=3, assert wr_en=rd_en=1 → state=001; count, head and tail unchanged; we_rf=re_rf=0.
- Interleaved pointers: starting from head=tail=5 (reached by 5 writes then 5 reads), do 4 writes and 2 reads → tail=1, head=7, count=2; invariant (tail−head) mod 8 = 2 holds.
- Reset mid-stream: at count=6, drop reset_n between edges → all outputs go to zero/INIT at once without waiting for clk. The next write after release yields count=1, tail=1.
